// File: rtl/avr_adc_scanner.sv
// Two-byte AVR ADC frame decoder with masked round-robin channel scan, sample bank and sticky errors.
// Optional feature macro: AVR_ADC_AVG_EN (bank stores an exponential average instead of raw samples).
module avr_adc_scanner #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned SAMPLE_W  = 10,
  parameter logic [15:0] CH_MASK   = 16'hFFFF,
  parameter int unsigned TIMEOUT   = 65535,
  parameter int unsigned AVG_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_done,
  input  logic [7:0]          spi_dout,
  input  logic                spi_ss,
  input  logic                scan_en,
  input  logic [3:0]          fixed_ch,
  input  logic [3:0]          rd_ch,
  output logic [3:0]          spi_channel,
  output logic                new_sample,
  output logic [SAMPLE_W-1:0] sample,
  output logic [3:0]          sample_channel,
  output logic [SAMPLE_W-1:0] rd_sample,
  output logic                rd_valid,
  output logic                err_mismatch,
  output logic                err_timeout,
  input  logic                err_clr
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [15:0] MASK_EFF = CH_MASK & 16'((33'h1 << NUM_CH) - 33'h1);
  localparam logic [3:0]  CH_MAX   = 4'(NUM_CH - 1);
  localparam logic [4:0]  NUM_CH5  = 5'(NUM_CH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  generate
    if (NUM_CH < 1 || NUM_CH > 16 || SAMPLE_W < 8 || SAMPLE_W > 12 ||
        TIMEOUT < 1 || TIMEOUT > 65535 || AVG_SHIFT < 1 || AVG_SHIFT > 4 ||
        MASK_EFF == 16'h0) begin : g_bad_param
      $error("avr_adc_scanner: parameter out of range");
    end
  endgenerate

  // Lowest enabled channel at or above start, wrapping to the lowest enabled channel.
  function automatic logic [3:0] next_en(input logic [3:0] start);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (MASK_EFF[i]) r = 4'(i);
    for (int i = 15; i >= 0; i--) if (MASK_EFF[i] && 4'(i) >= start) r = 4'(i);
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [7:0]          lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          ch_q, ch_d;
  logic                scan_q, scan_d;
  logic                new_q, new_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [3:0]          sch_q, sch_d;
  logic [SAMPLE_W-1:0] bank_q [NUM_CH];
  logic [SAMPLE_W-1:0] bank_d [NUM_CH];
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic                errm_q, errm_d;
  logic                errt_q, errt_d;

  logic [3:0]          frame_ch;
  logic [SAMPLE_W-1:0] frame_sample;
  logic [SAMPLE_W-1:0] wr_val;
  logic                accept, tmo, counting;

  assign frame_ch = spi_dout[7:4];

  generate
    if (SAMPLE_W > 8) begin : g_wide
      assign frame_sample = {spi_dout[SAMPLE_W-9:0], lo_q};
    end else begin : g_narrow
      assign frame_sample = lo_q;
    end
  endgenerate

`ifdef AVR_ADC_AVG_EN
  logic signed [SAMPLE_W:0] avg_old, avg_diff, avg_res;
  // First write stores raw; later writes move 1/2^AVG_SHIFT of the way toward the new sample.
  always_comb begin
    avg_old  = $signed({1'b0, bank_q[frame_ch]});
    avg_diff = $signed({1'b0, frame_sample}) - avg_old;
    avg_res  = avg_old + (avg_diff >>> AVG_SHIFT);
    wr_val   = valid_q[frame_ch] ? avg_res[SAMPLE_W-1:0] : frame_sample;
  end
`else
  assign wr_val = frame_sample;
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    scan_d   = scan_en;
    new_d    = 1'b0;
    sample_d = sample_q;
    sch_d    = sch_q;
    bank_d   = bank_q;
    valid_d  = valid_q;
    errm_d   = errm_q;
    errt_d   = errt_q;
    accept   = 1'b0;
    tmo      = 1'b0;

    if (err_clr) begin
      errm_d = 1'b0;
      errt_d = 1'b0;
    end

    if (spi_ss) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LO;
        S_LO: if (spi_done) begin
          lo_d    = spi_dout;
          state_d = S_HI;
        end
        S_HI: if (spi_done) begin
          state_d = S_DONE;
          if ({1'b0, frame_ch} < NUM_CH5 && frame_ch == ch_q) accept = 1'b1;
          else errm_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (accept) begin
      new_d             = 1'b1;
      sample_d          = frame_sample;
      sch_d             = frame_ch;
      bank_d[frame_ch]  = wr_val;
      valid_d[frame_ch] = 1'b1;
    end

    counting = spi_ss || state_q == S_LO || state_q == S_HI;
    if (accept) begin
      cnt_d = '0;
    end else if (counting) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        tmo    = 1'b1;
        errt_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Fixed mode tracks fixed_ch every cycle; entering scan mode resyncs to the enabled set.
    if (!scan_en) ch_d = ({1'b0, fixed_ch} < NUM_CH5) ? fixed_ch : CH_MAX;
    else if (!scan_q) ch_d = next_en(ch_q);
    else if (accept || tmo) ch_d = next_en(ch_q + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      cnt_q    <= '0;
      ch_q     <= next_en(4'd0);
      scan_q   <= 1'b0;
      new_q    <= 1'b0;
      sample_q <= '0;
      sch_q    <= '0;
      bank_q   <= '{default: '0};
      valid_q  <= '0;
      errm_q   <= 1'b0;
      errt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      scan_q   <= scan_d;
      new_q    <= new_d;
      sample_q <= sample_d;
      sch_q    <= sch_d;
      bank_q   <= bank_d;
      valid_q  <= valid_d;
      errm_q   <= errm_d;
      errt_q   <= errt_d;
    end
  end

  assign spi_channel    = ch_q;
  assign new_sample     = new_q;
  assign sample         = sample_q;
  assign sample_channel = sch_q;
  assign err_mismatch   = errm_q;
  assign err_timeout    = errt_q;
  assign rd_sample      = ({1'b0, rd_ch} < NUM_CH5) ? bank_q[rd_ch] : '0;
  assign rd_valid       = ({1'b0, rd_ch} < NUM_CH5) && valid_q[rd_ch];

endmodule
